tone_detector: RTL
==================

TONE_DETECTOR -- requirements
Module: tone_detector

Interface
REQ-001 Parameter TOL_SHIFT, default 6: match tolerance per note is NOM_PERIOD[k] >> TOL_SHIFT clk1 cycles.
REQ-002 Parameter MATCH_COUNT, default 2: consecutive matching periods required to lock.
REQ-003 clk1  input  1  single system clock, 50 MHz, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk1.
REQ-005 tone_in  input  1  asynchronous square-wave input, nominally one of the eight scale tones.
REQ-006 note_valid  output  1  high while a tone is locked.
REQ-007 note_code  output  3  locked note: 0=C1, 1=D, 2=E, 3=F, 4=G, 5=A, 6=B, 7=C2; valid only with note_valid.
REQ-008 note_onehot  output  8  bit note_code set when note_valid, else all zero.
REQ-009 period_out  output  18  last measured tone_in period in clk1 cycles.
REQ-010 period_strobe  output  1  one-cycle pulse when period_out updates.

Function
REQ-011 tone_in SHALL pass a 2-flop synchronizer; a rising edge sampled at clk1 edge n SHALL give an internal edge pulse in cycle n+2.
REQ-012 Nominal full periods: 190840, 170348, 151596, 143266, 127552, 113636, 101208, 95442 cycles for codes 0..7.
REQ-013 States SHALL be IDLE, MEASURE, LOCKED; reset enters IDLE.
REQ-014 IDLE: first edge pulse clears the period counter to 0, moves to MEASURE; no period_strobe.
REQ-015 Period counter SHALL increment every cycle, clear to 0 on each edge pulse, and saturate at 262143.
REQ-016 On an edge pulse in MEASURE/LOCKED, measured period P = counter+1; period_out, period_strobe, note outputs SHALL update in the following cycle (n+3).
REQ-017 P matches code k iff |P - NOM_PERIOD[k]| <= NOM_PERIOD[k] >> TOL_SHIFT; at most one k matches with default tolerance.
REQ-018 Match equal to current candidate: match counter increments (saturating at MATCH_COUNT); on reaching MATCH_COUNT enter LOCKED, note_valid=1, note_code=candidate.
REQ-019 Match to a different code: candidate=new code, match counter=1, note_valid=0, state MEASURE.
REQ-020 No match: match counter=0, note_valid=0, state MEASURE.
REQ-021 Counter saturation (no edge for 262143 cycles) in MEASURE/LOCKED: note_valid=0, match counter=0, state IDLE, in the cycle after saturation.
REQ-022 Edge pulse in the same cycle as saturation: the edge wins; P=262144 is treated as no match.
REQ-023 Absolute difference SHALL be computed at 19 bits signed; no truncation of NOM_PERIOD.

Reset
REQ-024 Reset SHALL set note_valid=0, note_code=0, note_onehot=0, period_out=0, period_strobe=0, counters=0, candidate=0, synchronizer flops=0, state IDLE.
REQ-025 Reset asserted mid-measurement or while LOCKED SHALL take effect on the next clk1 edge and discard any partial period; the first edge after reset release is treated as an IDLE edge.

Structure
REQ-026 Package tone_pkg SHALL hold NOM_PERIOD table, note code constants, PERIOD_W=18, CODE_W=3, and the state enumeration, for sharing with the tone generator.
REQ-027 Sub-module tone_sync_edge SHALL implement the synchronizer and rising-edge pulse; classification and FSM stay in tone_detector.

Verification
REQ-028 Square wave period 151596 -> period_strobe with period_out=151596 each edge; note_valid=1, note_code=2, note_onehot=8'b0000_0100 after the 2nd measured period.
REQ-029 Period 151596+2368 -> matches E; period 151596+2369 -> no match, note_valid stays 0.
REQ-030 Locked on G (127552), switch to A (113636) -> note_valid=0 at first A period, re-asserts code 5 at second.
REQ-031 Locked on C2, tone_in held static -> note_valid=0 and state IDLE 262144 cycles after last edge pulse.
REQ-032 Reset pulsed while locked on D -> all outputs 0 next cycle; relock needs one IDLE edge plus MATCH_COUNT periods.
REQ-033 tone_in edge 1 cycle before clk1 edge (metastability window) -> no X propagation; period_out within ±1 cycle of nominal.

Source files
------------

// File: rtl/tone_pkg.sv
// tone_pkg: definitions shared by the tone detector and the tone generator.
// It holds the nominal full period of each scale tone in clk1 cycles, the note
// code constants, the common widths and the detector state encoding.
package tone_pkg;

  localparam int unsigned PERIOD_W  = 18;
  localparam int unsigned CODE_W    = 3;
  localparam int unsigned NUM_NOTES = 8;

  localparam logic [CODE_W-1:0] NOTE_C1 = 3'd0;
  localparam logic [CODE_W-1:0] NOTE_D  = 3'd1;
  localparam logic [CODE_W-1:0] NOTE_E  = 3'd2;
  localparam logic [CODE_W-1:0] NOTE_F  = 3'd3;
  localparam logic [CODE_W-1:0] NOTE_G  = 3'd4;
  localparam logic [CODE_W-1:0] NOTE_A  = 3'd5;
  localparam logic [CODE_W-1:0] NOTE_B  = 3'd6;
  localparam logic [CODE_W-1:0] NOTE_C2 = 3'd7;

  // Full period of each tone at a 50 MHz clk1, indexed by note code.
  localparam logic [PERIOD_W-1:0] NOM_PERIOD [NUM_NOTES] = '{
    18'd190840, 18'd170348, 18'd151596, 18'd143266,
    18'd127552, 18'd113636, 18'd101208, 18'd95442
  };

  typedef enum logic [1:0] {StIdle, StMeasure, StLocked} state_t;

  // |(cnt + 1) - nom| using a 19-bit signed difference. The +1 is folded in
  // after the subtraction so a saturated counter (P = 2^18) cannot overflow.
  function automatic logic [PERIOD_W:0] period_dist(input logic [PERIOD_W-1:0] cnt,
                                                    input logic [PERIOD_W-1:0] nom);
    logic signed [PERIOD_W:0] d;
    logic        [PERIOD_W:0] mag;
    d = $signed({1'b0, cnt}) - $signed({1'b0, nom}) + $signed({{PERIOD_W{1'b0}}, 1'b1});
    if (d < 0) mag = $unsigned(-d);
    else       mag = $unsigned(d);
    return mag;
  endfunction

endpackage

// File: rtl/tone_sync_edge.sv
// tone_sync_edge: two-flop synchronizer for the asynchronous tone input plus
// a registered rising-edge detector.
// A rising edge sampled at clk1 edge n gives edge_pulse high during cycle n+2.
//   clk1       - system clock
//   reset      - synchronous active-high reset
//   tone_in    - asynchronous square wave
//   edge_pulse - one-cycle pulse per synchronized rising edge
module tone_sync_edge (
  input  logic clk1,
  input  logic reset,
  input  logic tone_in,
  output logic edge_pulse
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk1) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync1_q    <= tone_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      edge_pulse <= sync2_q & ~prev_q;
    end
  end

endmodule

// File: rtl/tone_detector.sv
// tone_detector: measures the period of a square-wave tone and locks onto one
// of eight scale notes after MATCH_COUNT consecutive matching periods.
//   clk1          - 50 MHz system clock
//   reset         - synchronous active-high reset
//   tone_in       - asynchronous tone input
//   note_valid    - high while a note is locked
//   note_code     - locked note code (meaningful only with note_valid)
//   note_onehot   - one-hot of note_code while locked, else zero
//   period_out    - last measured period in clk1 cycles
//   period_strobe - one-cycle pulse when period_out updates
module tone_detector
  import tone_pkg::*;
#(
  parameter int unsigned TOL_SHIFT   = 6,
  parameter int unsigned MATCH_COUNT = 2
) (
  input  logic                 clk1,
  input  logic                 reset,
  input  logic                 tone_in,
  output logic                 note_valid,
  output logic [CODE_W-1:0]    note_code,
  output logic [NUM_NOTES-1:0] note_onehot,
  output logic [PERIOD_W-1:0]  period_out,
  output logic                 period_strobe
);

  localparam int unsigned MC_W = $clog2(MATCH_COUNT + 1);

  logic                edge_pulse;
  state_t              state_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [MC_W-1:0]     mcnt_q;
  logic [CODE_W-1:0]   cand_q;
  logic                sat;
  logic                hit;
  logic [CODE_W-1:0]   hit_code;

  tone_sync_edge u_sync (
    .clk1       (clk1),
    .reset      (reset),
    .tone_in    (tone_in),
    .edge_pulse (edge_pulse)
  );

  assign sat = (cnt_q == '1);

  // Classify the period that ends on this edge; lowest code wins a tie, which
  // cannot happen with the default tolerance.
  always_comb begin
    hit      = 1'b0;
    hit_code = '0;
    for (int k = NUM_NOTES - 1; k >= 0; k--) begin
      if (period_dist(cnt_q, NOM_PERIOD[k]) <= ({1'b0, NOM_PERIOD[k]} >> TOL_SHIFT)) begin
        hit      = 1'b1;
        hit_code = CODE_W'(k);
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      mcnt_q        <= '0;
      cand_q        <= '0;
      note_valid    <= 1'b0;
      note_code     <= '0;
      note_onehot   <= '0;
      period_out    <= '0;
      period_strobe <= 1'b0;
    end else begin
      period_strobe <= 1'b0;

      if (edge_pulse) cnt_q <= '0;
      else if (!sat)  cnt_q <= cnt_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (edge_pulse) state_q <= StMeasure;
        end
        StMeasure, StLocked: begin
          if (edge_pulse) begin
            // A saturated counter means P = 2^18, which does not fit; report max.
            period_out    <= sat ? '1 : cnt_q + 1'b1;
            period_strobe <= 1'b1;
            if (!hit) begin
              mcnt_q      <= '0;
              note_valid  <= 1'b0;
              note_onehot <= '0;
              state_q     <= StMeasure;
            end else if (hit_code == cand_q) begin
              if (mcnt_q >= MC_W'(MATCH_COUNT - 1)) begin
                mcnt_q      <= MC_W'(MATCH_COUNT);
                note_valid  <= 1'b1;
                note_code   <= cand_q;
                note_onehot <= NUM_NOTES'(1) << cand_q;
                state_q     <= StLocked;
              end else begin
                mcnt_q <= mcnt_q + 1'b1;
              end
            end else begin
              cand_q      <= hit_code;
              mcnt_q      <= MC_W'(1);
              note_valid  <= 1'b0;
              note_onehot <= '0;
              state_q     <= StMeasure;
            end
          end else if (sat) begin
            // Tone vanished: drop the lock and wait for a fresh first edge.
            mcnt_q      <= '0;
            note_valid  <= 1'b0;
            note_onehot <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
